mult_arb_2ch: RTL and testbench
===============================

# mult_arb_2ch

Two-channel arbiter and sequencer for a shared shift-add multiplier. Accepts operand pairs from two independent requesters over valid/ready handshakes, grants one at a time, runs the multiplier core for OP_W iterations and returns the product to the granted channel with a held response handshake. Sits between requester blocks and the single multiplier datapath so the multiplier is never duplicated.

## Interface
- OP_W, 4, operand width; product is 2*OP_W bits; iteration count = OP_W
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req0_valid_i / req1_valid_i  in  1  channel request valid
- req0_ready_o / req1_ready_o  out  1  channel request accepted this cycle
- req0_a_i / req1_a_i  in  OP_W  multiplicand
- req0_b_i / req1_b_i  in  OP_W  multiplier
- resp0_valid_o / resp1_valid_o  out  1  product valid for channel
- resp0_ready_i / resp1_ready_i  in  1  channel consumes product
- y_o  out  2*OP_W  product, shared by both channels, meaningful only while a resp*_valid_o is high
- busy_o  out  1  high in any state other than ARB_IDLE
- fsm_state_o  out  2  current arbiter state encoding

## Operation
- States: ARB_IDLE, ARB_RUN, ARB_RESP.
- ARB_IDLE: grant computed combinationally from valids; granted req*_ready_o high, other low. Accept edge (valid&&ready): latch a, b, channel id; clear accumulator; bit counter = 0; go ARB_RUN. No valid -> stay.
- ARB_RUN: each cycle, if b[0] then acc += a; a <<= 1 (2*OP_W wide, zero-extended); b >>= 1; counter++. After OP_W iterations -> ARB_RESP.
- ARB_RESP: resp*_valid_o of latched channel high, y_o = acc held stable. On matching resp*_ready_i high -> ARB_IDLE; otherwise hold indefinitely. Ready of the other channel ignored.
- Both ready outputs low outside ARB_IDLE; requesters hold valid and operands until accepted.
- Accumulator is 2*OP_W bits; max product (2^OP_W-1)^2 never overflows.
- Operand changes after accept edge have no effect on current operation.
- Reset (any state, including mid-RUN/RESP): immediate return to ARB_IDLE; accumulator, operands, counter cleared; in-flight operation discarded, no response produced.

## Timing
- Reset values: all ready/valid outputs 0, y_o 0, busy_o 0, fsm_state_o = ARB_IDLE.
- Accept at edge E0; iterations at E1..E_OP_W; resp*_valid_o high after edge E_OP_W (latency OP_W cycles from accept, 4 for default).
- Response consumed at edge Ek; earliest next accept at edge Ek+1. Minimum period OP_W+2 cycles per operation.
- req*_ready_o depends combinationally on req*_valid_i and state; no combinational path from resp*_ready_i to any output.

## Configuration
- MULT_ARB_RR_EN defined: round-robin; one-bit last-served pointer, reset value = channel 1 (so channel 0 wins first tie); on tie, grant channel not last served; pointer updated on each accept.
- Undefined: fixed priority, channel 0 always wins a tie; no pointer register.
- Single-requester behaviour identical in both builds.

## Structure
- Package mult_arb_pkg: arb_state_t enum (ARB_IDLE=2'd0, ARB_RUN=2'd1, ARB_RESP=2'd2), channel-id constants CH0/CH1.
- Sub-module mult_shift_add_core: start_i, a_i, b_i, y_o, done_o pulse after OP_W iterations; arbiter instantiates one, drives start on accept, moves to ARB_RESP on done_o.

## Test plan
- Ch0 only, a=3 b=5 -> req0_ready_o high at accept, resp0_valid_o after 4 cycles, y_o=15, resp1_valid_o stays 0.
- Ch1 only, a=15 b=15 -> y_o=225 (8'hE1); a=0 b=13 -> y_o=0.
- Both valid continuously (ch0 7x9, ch1 2x6), resp readies tied high -> RR build: ch0 (63), ch1 (12), ch0, ch1; fixed build: ch0 every time, ch1 starved.
- resp0_ready_i low for 10 cycles after result -> resp0_valid_o and y_o stable, both req readies 0, busy_o 1; ready high -> ARB_IDLE next edge.
- Change req0_a_i/b_i after accept -> product reflects latched values only.
- Assert rst_i two cycles into ARB_RUN -> all outputs 0 immediately, state ARB_IDLE, no response; after release new request 4x4 -> y_o=16 normally.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state encoding and channel ids for the two-channel multiplier arbiter
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RUN  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/mult_shift_add_core.sv
// rtl/mult_shift_add_core.sv - shift-add multiplier core, OP_W iterations per product
module mult_shift_add_core
  import mult_arb_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [2*OP_W-1:0] y_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(OP_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OP_W - 1);

  logic [2*OP_W-1:0] a_q;
  logic [2*OP_W-1:0] acc_q;
  logic [OP_W-1:0]   b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      a_q   <= {{OP_W{1'b0}}, a_i};
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (b_q[0]) begin
        acc_q <= acc_q + a_q;
      end
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST_ITER) begin
        run_q <= 1'b0;
      end
    end
  end

  // High during the final iteration cycle so the owner can switch state on the same edge the product lands.
  assign done_o = run_q && (cnt_q == LAST_ITER);
  assign y_o    = acc_q;

endmodule

// File: rtl/mult_arb_2ch.sv
// rtl/mult_arb_2ch.sv - two-channel arbiter for a shared multiplier; MULT_ARB_RR_EN selects round-robin
module mult_arb_2ch
  import mult_arb_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OP_W-1:0]   req0_a_i,
  input  logic [OP_W-1:0]   req0_b_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OP_W-1:0]   req1_a_i,
  input  logic [OP_W-1:0]   req1_b_i,
  output logic              resp0_valid_o,
  input  logic              resp0_ready_i,
  output logic              resp1_valid_o,
  input  logic              resp1_ready_i,
  output logic [2*OP_W-1:0] y_o,
  output logic              busy_o,
  output logic [1:0]        fsm_state_o
);

  arb_state_t      state_q;
  logic            ch_q;
  logic            resp0_q;
  logic            resp1_q;
  logic            gnt0;
  logic            gnt1;
  logic            accept;
  logic            core_done;
  logic [OP_W-1:0] core_a;
  logic [OP_W-1:0] core_b;

`ifdef MULT_ARB_RR_EN
  logic last_q;

  assign gnt0 = req0_valid_i && (!req1_valid_i || last_q == CH1);
  assign gnt1 = req1_valid_i && (!req0_valid_i || last_q == CH0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= CH1;
    end else if (accept) begin
      last_q <= gnt1 ? CH1 : CH0;
    end
  end
`else
  assign gnt0 = req0_valid_i;
  assign gnt1 = req1_valid_i && !req0_valid_i;
`endif

  // Readies are masked during reset so no request can be accepted while the core is held cleared.
  assign req0_ready_o = !rst_i && (state_q == ARB_IDLE) && gnt0;
  assign req1_ready_o = !rst_i && (state_q == ARB_IDLE) && gnt1;
  assign accept       = req0_ready_o || req1_ready_o;
  assign core_a       = gnt1 ? req1_a_i : req0_a_i;
  assign core_b       = gnt1 ? req1_b_i : req0_b_i;

  mult_shift_add_core #(
    .OP_W (OP_W)
  ) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (accept),
    .a_i     (core_a),
    .b_i     (core_b),
    .y_o     (y_o),
    .done_o  (core_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ch_q    <= CH0;
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            ch_q    <= gnt1 ? CH1 : CH0;
            state_q <= ARB_RUN;
          end
        end
        ARB_RUN: begin
          if (core_done) begin
            state_q <= ARB_RESP;
            resp0_q <= (ch_q == CH0);
            resp1_q <= (ch_q == CH1);
          end
        end
        ARB_RESP: begin
          if ((ch_q == CH0) ? resp0_ready_i : resp1_ready_i) begin
            state_q <= ARB_IDLE;
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign resp0_valid_o = resp0_q;
  assign resp1_valid_o = resp1_q;
  assign busy_o        = (state_q != ARB_IDLE);
  assign fsm_state_o   = state_q;

endmodule

// File: tb/tb_mult_arb_2ch.sv
// tb/tb_mult_arb_2ch.sv - self-checking bench for mult_arb_2ch against a transaction-level model
module tb_mult_arb_2ch;

  localparam int OP_W = 4;
  localparam int YW   = 2 * OP_W;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req0_valid_i, req1_valid_i;
  logic            req0_ready_o, req1_ready_o;
  logic [OP_W-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic            resp0_valid_o, resp1_valid_o;
  logic            resp0_ready_i, resp1_ready_i;
  logic [YW-1:0]   y_o;
  logic            busy_o;
  logic [1:0]      fsm_state_o;

  int n_cmp = 0;
  int n_bad = 0;

  mult_arb_2ch #(.OP_W(OP_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req0_valid_i  (req0_valid_i),
    .req0_ready_o  (req0_ready_o),
    .req0_a_i      (req0_a_i),
    .req0_b_i      (req0_b_i),
    .req1_valid_i  (req1_valid_i),
    .req1_ready_o  (req1_ready_o),
    .req1_a_i      (req1_a_i),
    .req1_b_i      (req1_b_i),
    .resp0_valid_o (resp0_valid_o),
    .resp0_ready_i (resp0_ready_i),
    .resp1_valid_o (resp1_valid_o),
    .resp1_ready_i (resp1_ready_i),
    .y_o           (y_o),
    .busy_o        (busy_o),
    .fsm_state_o   (fsm_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Grant rule: bit0 = channel 0, bit1 = channel 1.
  function automatic logic [1:0] grant(input logic v0, input logic v1, input logic last);
    logic [1:0] g;
    g = {v1, v0};
    if (v0 && v1) begin
`ifdef MULT_ARB_RR_EN
      g = last ? 2'b01 : 2'b10;
`else
      g = 2'b01;
`endif
    end
    return g;
  endfunction

  // Transaction model: phase 0 idle, 1 computing, 2 responding.
  int            m_phase;
  int            m_rem;
  logic          m_ch;
  logic          m_last;
  logic [YW-1:0] m_y;
  logic [1:0]    m_g;

  assign m_g = grant(req0_valid_i, req1_valid_i, m_last);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_phase <= 0;
      m_rem   <= 0;
      m_ch    <= 1'b0;
      m_last  <= 1'b1;
      m_y     <= '0;
    end else begin
      case (m_phase)
        0: if (m_g != 2'b00) begin
          m_ch    <= m_g[1];
          m_last  <= m_g[1];
          m_y     <= m_g[1] ? YW'(req1_a_i) * YW'(req1_b_i) : YW'(req0_a_i) * YW'(req0_b_i);
          m_rem   <= OP_W;
          m_phase <= 1;
        end
        1: begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_phase <= 2;
        end
        default: if (m_ch ? resp1_ready_i : resp0_ready_i) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk_i) begin
    logic [1:0] e_rdy, e_resp, e_st;
    logic       e_busy;
    if (rst_i) begin
      e_rdy = 2'b00; e_resp = 2'b00; e_busy = 1'b0; e_st = 2'd0;
      chk("cyc_y_rst", 32'(y_o), 32'd0);
    end else begin
      e_rdy  = (m_phase == 0) ? m_g : 2'b00;
      e_resp = (m_phase == 2) ? (m_ch ? 2'b10 : 2'b01) : 2'b00;
      e_busy = (m_phase != 0);
      e_st   = 2'(m_phase);
      if (m_phase == 2) chk("cyc_y", 32'(y_o), 32'(m_y));
    end
    chk("cyc_ready", 32'({req1_ready_o, req0_ready_o}), 32'(e_rdy));
    chk("cyc_resp_valid", 32'({resp1_valid_o, resp0_valid_o}), 32'(e_resp));
    chk("cyc_busy", 32'(busy_o), 32'(e_busy));
    chk("cyc_state", 32'(fsm_state_o), 32'(e_st));
  end

  // Observed completed responses and accepted requests, for directed ordering checks and the random driver.
  int            obs_ch[$];
  logic [YW-1:0] obs_y[$];
  logic          acc0, acc1;

  always @(negedge clk_i) begin
    acc0 <= req0_valid_i && req0_ready_o;
    acc1 <= req1_valid_i && req1_ready_o;
    if (!rst_i) begin
      if (resp0_valid_o && resp0_ready_i) begin obs_ch.push_back(0); obs_y.push_back(y_o); end
      if (resp1_valid_o && resp1_ready_i) begin obs_ch.push_back(1); obs_y.push_back(y_o); end
    end
  end

  task automatic run_op(input logic ch, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                        input logic [YW-1:0] exp_y);
    if (ch) begin req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; end
    else    begin req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; end
    #1;
    chk("op_ready", 32'(ch ? req1_ready_o : req0_ready_o), 32'd1);
    tick();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    repeat (OP_W - 1) tick();
    chk("op_resp_early", 32'({resp1_valid_o, resp0_valid_o}), 32'd0);
    tick();
    chk("op_resp_valid", 32'({resp1_valid_o, resp0_valid_o}), ch ? 32'd2 : 32'd1);
    chk("op_y", 32'(y_o), 32'(exp_y));
    chk("model_y", 32'(m_y), 32'(exp_y));
    resp0_ready_i = 1'b1;
    resp1_ready_i = 1'b1;
    tick();
    resp0_ready_i = 1'b0;
    resp1_ready_i = 1'b0;
    chk("op_idle", 32'(fsm_state_o), 32'd0);
  endtask

  initial begin
    int e_ch;
    rst_i = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_a_i = '0; req0_b_i = '0; req1_a_i = '0; req1_b_i = '0;
    resp0_ready_i = 1'b0; resp1_ready_i = 1'b0;
    tick();
    chk("rst_outputs", 32'({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, busy_o}), 32'd0);
    chk("rst_y", 32'(y_o), 32'd0);
    chk("rst_state", 32'(fsm_state_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    run_op(1'b0, 4'd3, 4'd5, 8'd15);
    run_op(1'b1, 4'd15, 4'd15, 8'hE1);
    run_op(1'b1, 4'd0, 4'd13, 8'd0);

    // Both channels requesting continuously with responses always taken.
    obs_ch.delete(); obs_y.delete();
    resp0_ready_i = 1'b1; resp1_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_a_i = 4'd7; req0_b_i = 4'd9;
    req1_valid_i = 1'b1; req1_a_i = 4'd2; req1_b_i = 4'd6;
    repeat (4 * (OP_W + 2)) tick();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();
    resp0_ready_i = 1'b0; resp1_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef MULT_ARB_RR_EN
      e_ch = i % 2;
`else
      e_ch = 0;
`endif
      if (i < obs_ch.size()) begin
        chk("both_ch", 32'(obs_ch[i]), 32'(e_ch));
        chk("both_y", 32'(obs_y[i]), (e_ch == 1) ? 32'd12 : 32'd63);
      end else begin
        chk("both_count", 32'(obs_ch.size()), 32'd4);
      end
    end

    // Response held off for 10 cycles while the other channel waits.
    req0_valid_i = 1'b1; req0_a_i = 4'd6; req0_b_i = 4'd7;
    tick();
    req0_valid_i = 1'b0;
    repeat (OP_W) tick();
    req1_valid_i = 1'b1; req1_a_i = 4'd1; req1_b_i = 4'd1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_resp0", 32'(resp0_valid_o), 32'd1);
      chk("hold_y", 32'(y_o), 32'd42);
      chk("hold_readies", 32'({req1_ready_o, req0_ready_o}), 32'd0);
      chk("hold_busy", 32'(busy_o), 32'd1);
      tick();
    end
    resp0_ready_i = 1'b1;
    tick();
    resp0_ready_i = 1'b0;
    chk("hold_release_state", 32'(fsm_state_o), 32'd0);
    chk("hold_release_ready1", 32'(req1_ready_o), 32'd1);
    tick();
    req1_valid_i = 1'b0;
    repeat (OP_W) tick();
    chk("hold_next_y", 32'(y_o), 32'd1);
    resp1_ready_i = 1'b1;
    tick();
    resp1_ready_i = 1'b0;

    // Operands change right after accept; the latched pair must win.
    req0_valid_i = 1'b1; req0_a_i = 4'd5; req0_b_i = 4'd6;
    tick();
    req0_valid_i = 1'b0; req0_a_i = 4'd15; req0_b_i = 4'd15;
    repeat (OP_W) tick();
    chk("latch_y", 32'(y_o), 32'd30);
    resp0_ready_i = 1'b1;
    tick();
    resp0_ready_i = 1'b0;

    // Reset two cycles into the computation.
    obs_ch.delete(); obs_y.delete();
    req0_valid_i = 1'b1; req0_a_i = 4'd9; req0_b_i = 4'd9;
    tick();
    req0_valid_i = 1'b0;
    repeat (2) tick();
    req1_valid_i = 1'b1;
    rst_i = 1'b1;
    #1;
    chk("midrst_outputs", 32'({req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, busy_o}), 32'd0);
    chk("midrst_y", 32'(y_o), 32'd0);
    chk("midrst_state", 32'(fsm_state_o), 32'd0);
    tick();
    req1_valid_i = 1'b0;
    rst_i = 1'b0;
    resp0_ready_i = 1'b1; resp1_ready_i = 1'b1;
    repeat (OP_W + 2) tick();
    resp0_ready_i = 1'b0; resp1_ready_i = 1'b0;
    chk("midrst_no_resp", 32'(obs_ch.size()), 32'd0);
    run_op(1'b0, 4'd4, 4'd4, 8'd16);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!req0_valid_i || acc0) begin
        req0_valid_i = ($urandom_range(0, 2) == 0);
        req0_a_i = 4'($urandom);
        req0_b_i = 4'($urandom);
      end
      if (!req1_valid_i || acc1) begin
        req1_valid_i = ($urandom_range(0, 2) == 0);
        req1_a_i = 4'($urandom);
        req1_b_i = 4'($urandom);
      end
      resp0_ready_i = ($urandom_range(0, 3) != 0);
      resp1_ready_i = ($urandom_range(0, 3) != 0);
      rst_i = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst_i = 1'b0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
